// File: rtl/vec_op_sequencer_pkg.sv
// rtl/vec_op_sequencer_pkg.sv - shared constants, opcodes and FSM encoding for the vector op sequencer
package vec_op_sequencer_pkg;

  localparam int LANES = 16;
  localparam int WIDTH = 16;
  localparam int VEC_W = LANES * WIDTH;

  // Opcode encodings match the ALU decode
  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;

  localparam logic FU_ADD = 1'b0;
  localparam logic FU_MUL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_VADD) || (op == OP_VDOT) || (op == OP_SMUL);
  endfunction

endpackage

// File: rtl/vec_op_sequencer_lane_sel.sv
// rtl/vec_op_sequencer_lane_sel.sv - combinational lane extract from two operand vectors and single-lane write-back
module vec_lane_sel
  import vec_op_sequencer_pkg::*;
(
  input  logic [VEC_W-1:0] vec_a,
  input  logic [VEC_W-1:0] vec_b,
  input  logic [3:0]       rd_idx,
  output logic [WIDTH-1:0] lane_a,
  output logic [WIDTH-1:0] lane_b,
  input  logic [VEC_W-1:0] wr_vec,
  input  logic [3:0]       wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  output logic [VEC_W-1:0] wr_out
);

  assign lane_a = vec_a[rd_idx*WIDTH +: WIDTH];
  assign lane_b = vec_b[rd_idx*WIDTH +: WIDTH];

  always_comb begin
    wr_out = wr_vec;
    wr_out[wr_idx*WIDTH +: WIDTH] = wr_data;
  end

endmodule

// File: rtl/vec_op_sequencer.sv
// rtl/vec_op_sequencer.sv - sequences VADD/VDOT/SMUL over 16 half-float lanes through one shared FU
module vec_op_sequencer
  import vec_op_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [VEC_W-1:0] op_1,
  input  logic [VEC_W-1:0] op_2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [VEC_W-1:0] result,
  output logic             fu_req,
  output logic             fu_op,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  input  logic             fu_ack,
  input  logic [WIDTH-1:0] fu_result
);

  localparam logic [3:0] LAST_LANE = 4'(LANES - 1);

  state_t           state;
  logic [3:0]       op_q;
  logic [3:0]       idx;
  logic [VEC_W-1:0] op1_q;
  logic [VEC_W-1:0] op2_q;
  logic [VEC_W-1:0] work;
  logic [VEC_W-1:0] work_wr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lane_a;
  logic [WIDTH-1:0] lane_b;
  logic             vdot;
  logic             need_add;
  logic             final_ack;

  // Reads look one lane ahead so the next operand set is ready on the ack cycle
  vec_lane_sel u_lane_sel (
    .vec_a   (op1_q),
    .vec_b   (op2_q),
    .rd_idx  (idx + 4'd1),
    .lane_a  (lane_a),
    .lane_b  (lane_b),
    .wr_vec  (work),
    .wr_idx  (idx),
    .wr_data (fu_result),
    .wr_out  (work_wr)
  );

  assign vdot      = (op_q == OP_VDOT);
  assign need_add  = vdot && (fu_op == FU_MUL) && (idx != 4'd0);
  assign final_ack = (idx == LAST_LANE) && !need_add;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      fu_req <= 1'b0;
      fu_op  <= FU_ADD;
      fu_a   <= '0;
      fu_b   <= '0;
      op_q   <= '0;
      idx    <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      work   <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= opcode;
            op1_q <= op_1;
            op2_q <= op_2;
            idx   <= '0;
            acc   <= '0;
            work  <= '0;
            if (is_legal(opcode)) begin
              busy   <= 1'b1;
              fu_req <= 1'b1;
              fu_op  <= (opcode == OP_VADD) ? FU_ADD : FU_MUL;
              fu_a   <= op_1[WIDTH-1:0];
              fu_b   <= op_2[WIDTH-1:0];
              state  <= ST_ISSUE;
            end else begin
              done   <= 1'b1;
              err    <= 1'b1;
              result <= '0;
              state  <= ST_FINISH;
            end
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (fu_ack) begin
            if (final_ack) begin
              state  <= ST_FINISH;
              busy   <= 1'b0;
              done   <= 1'b1;
              err    <= 1'b0;
              fu_req <= 1'b0;
              fu_op  <= FU_ADD;
              fu_a   <= '0;
              fu_b   <= '0;
              idx    <= '0;
              result <= vdot ? {{(VEC_W-WIDTH){1'b0}}, fu_result} : work_wr;
            end else begin
              state <= ST_ISSUE;
              if (need_add) begin
                // Product of lane idx folds into the running dot-product sum
                fu_op <= FU_ADD;
                fu_a  <= acc;
                fu_b  <= fu_result;
              end else begin
                idx   <= idx + 4'd1;
                fu_op <= (op_q == OP_VADD) ? FU_ADD : FU_MUL;
                fu_a  <= (op_q == OP_SMUL) ? op1_q[WIDTH-1:0] : lane_a;
                fu_b  <= lane_b;
                if (vdot) acc <= fu_result;
                else      work <= work_wr;
              end
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vec_op_sequencer.md
Name: vec_op_sequencer

Overview:
- Sequences multi-cycle vector opcodes (VADD, VDOT, SMUL) over 256-bit operands of 16 half-precision lanes.
- Issues one lane operation at a time to a single shared 16-bit float functional unit (FU) through a req/ack handshake.
- Sits between instruction decode and the FU. Returns a 256-bit result with a one-cycle done pulse.

Parameters:
- LANES, 16, number of vector lanes.
- WIDTH, 16, lane width in bits (half float). LANES*WIDTH = 256.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; accepted only when busy=0.
- opcode  in  4  VADD=4'b0000, VDOT=4'b0001, SMUL=4'b0010; all other codes are illegal.
- op_1  in  256  operand 1. Lane i is bits [16i+15:16i]. For SMUL, lane 0 is the scalar.
- op_2  in  256  operand 2.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse; result and err are valid in this cycle.
- err  out  1  set with done for an illegal opcode.
- result  out  256  final vector; held until the next accepted start.
- fu_req  out  1  FU request, level.
- fu_op  out  1  0=add, 1=mul.
- fu_a  out  16  FU operand A.
- fu_b  out  16  FU operand B.
- fu_ack  in  1  FU result valid, one cycle.
- fu_result  in  16  FU result.

Behaviour:
- Reset values: busy=0, done=0, err=0, result=0, fu_req=0, fu_op=0, fu_a=0, fu_b=0. Reset mid-operation aborts immediately; no done is produced for the aborted command.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE: on start, latch opcode, op_1 and op_2; clear lane index and accumulator; go to ISSUE (legal opcode) or FINISH (illegal opcode). busy rises the next cycle. start while busy=1 is ignored, and latched operands do not change.
- ISSUE/WAIT: fu_req, fu_op, fu_a and fu_b are registered and held stable until the cycle fu_ack=1.
  - fu_ack is honoured only while fu_req=1. fu_ack in IDLE or FINISH is ignored.
  - fu_ack arrives no earlier than the cycle after fu_req first rises.
  - On ack, if transactions remain, the next operands are presented in the following cycle with fu_req kept high (back-to-back). Otherwise go to FINISH.
- VADD: 16 transactions. Lane i: add(op_1[i], op_2[i]) -> result lane i.
- SMUL: 16 transactions. Lane i: mul(op_1[0], op_2[i]) -> result lane i.
- VDOT: 31 transactions. The pattern is mul lane 0 (loads acc), then for i=1..15: mul lane i, then add(acc, product) -> acc.
  - Final result: lane 0 = acc, lanes 1..15 = 0.
- FINISH: for one cycle, done=1, result/err updated, busy=0. Back to IDLE.
  - Illegal opcode: result=0, err=1, no FU transaction.
  - start in the FINISH cycle is ignored; it may be accepted the following cycle.
- Latency: with FU latency L (ack L cycles after fu_req rises for an operand set), the start-accept cycle to done is N*(L+1)+1 cycles, where N = 16 or 31. Illegal opcode: done 1 cycle after start.
- No arithmetic is performed in this block. Lane index is 4 bits, wraps only at command end, and is never reused mid-command.

Decomposition:
- Shared package/include: opcode constants (matching the ALU encoding), FU op encodings (FU_ADD, FU_MUL), LANES and WIDTH, and the FSM state encoding.
- One natural sub-module, vec_lane_sel: a combinational 256-to-16 lane extract and lane write-back with a 4-bit index. All else stays in the sequencer.

Test Plan:
- The bench FU model uses the team float functions with a programmable latency L.
- VADD, L=1: all op_1 lanes 0x3C00 (1.0), all op_2 lanes 0x4000 (2.0) -> all lanes 0x4200; done exactly 33 cycles after start; err=0; exactly 16 fu_req handshakes.
- VDOT, L=1: op_1 lanes 0x3C00, op_2 lanes 0x4000 -> lane 0 = 0x5000 (32.0), other lanes 0; done at cycle 63; 16 mul and 15 add transactions in the specified order.
- SMUL, L=3: op_1 lane 0 = 0x4000, op_2 lane i = 0x3C00 -> all lanes 0x4000; done at cycle 65; fu_a/fu_b stable while fu_req=1 and unacked.
- Illegal opcode 4'b0011 -> done and err=1 one cycle later, result=0, fu_req never asserted.
- start pulsed again while busy with different operands -> ignored; original result unchanged. Spurious fu_ack while idle -> no effect.
- rst asserted mid-VADD at lane 7 -> all outputs 0 the same cycle; no done. A new VADD after reset completes correctly.
